// File: rtl/bandit_pkg.sv
// Shared types and constants for the bandit reward environment and its agent.
// The LFSR step function is kept here so the agent's exploration generator can reuse it.
package bandit_pkg;

  typedef logic [7:0]        action_t;
  typedef logic signed [7:0] reward_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REWARD
  } env_state_t;

  // Galois form: shift right and fold the mask in when a one falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v, input logic [15:0] mask);
    return v[0] ? ((v >> 1) ^ mask) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances every cycle out of reset.
// A zero seed would lock up, so it is replaced with 1.
module lfsr16
  import bandit_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] MASK = LFSR_MASK
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] value
);

  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = lfsr_step(value_q, MASK);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      value_q <= SEED_NZ;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/bandit_environment.sv
// Reward environment: accepts one arm index at a time, draws a Bernoulli reward from a
// per-arm probability table and the LFSR, and returns it after a fixed delay.
//
//   state  | meaning
//   IDLE   | accepts config writes (priority) or one action
//   DELAY  | counting down to reward presentation; all inputs stalled
//   REWARD | reward_valid held with latched value until reward_ready
module bandit_environment
  import bandit_pkg::*;
#(
  parameter int          ACTIONS = 256,
  parameter int          LATENCY = 4,
  parameter reward_t     WIN     = reward_t'(64),
  parameter reward_t     LOSS    = reward_t'(-32),
  parameter reward_t     INVALID = reward_t'(-128),
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        action_valid,
  input  action_t     action_data,
  output logic        action_ready,
  output logic        reward_valid,
  output reward_t     reward_data,
  input  logic        reward_ready,
  input  logic        cfg_valid,
  input  action_t     cfg_addr,
  input  logic [7:0]  cfg_data,
  output logic        cfg_ready
);

  localparam int CNT_W = $clog2(LATENCY + 2);

  env_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  reward_t          reward_q, reward_d;

  logic [7:0]  tbl_q [256];
  logic [7:0]  tbl_rd;
  logic        tbl_we;
  logic [15:0] lfsr_val;
  logic [7:0]  lfsr_lo;
  logic [7:0]  lfsr_unused;
  reward_t     draw;

  lfsr16 #(
    .SEED (SEED),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (lfsr_val)
  );

  assign {lfsr_unused, lfsr_lo} = lfsr_val;
  assign tbl_rd = tbl_q[action_data];

  always_comb begin
    if (action_data == '0 || int'(action_data) >= ACTIONS) begin
      draw = INVALID;
    end else if (lfsr_lo < tbl_rd) begin
      draw = WIN;
    end else begin
      draw = LOSS;
    end
  end

  // DELAY always lasts LATENCY+1 cycles so reward_valid rises LATENCY+1 edges after acceptance.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    reward_d     = reward_q;
    action_ready = 1'b0;
    cfg_ready    = 1'b0;
    reward_valid = 1'b0;
    tbl_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready    = 1'b1;
        action_ready = !cfg_valid;
        tbl_we       = cfg_valid;
        if (action_valid && !cfg_valid) begin
          reward_d = draw;
          count_d  = CNT_W'(LATENCY + 1);
          state_d  = DELAY;
        end
      end
      DELAY: begin
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          state_d = REWARD;
        end
      end
      REWARD: begin
        reward_valid = 1'b1;
        if (reward_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      action_ready = 1'b0;
      cfg_ready    = 1'b0;
      reward_valid = 1'b0;
      tbl_we       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reward_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reward_q <= reward_d;
    end
  end

  // Table deliberately survives reset so a trained environment keeps its probabilities.
  always_ff @(posedge clock) begin
    if (tbl_we) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  assign reward_data = reset ? reward_q : '0;

endmodule

// File: tb/tb_bandit_environment.sv
// Self-checking bench for bandit_environment: reference LFSR and table model feed a
// scoreboard of expected rewards that is popped at each reward handshake.
module tb_bandit_environment;

  localparam int          LAT  = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       action_valid = 1'b0;
  logic [7:0] action_data = 8'd0;
  logic       action_ready;
  logic       reward_valid;
  logic [7:0] reward_data;
  logic       reward_ready = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_addr = 8'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       cfg_ready;

  int checks = 0;
  int failures = 0;

  logic [15:0] lfsr_m;
  logic [7:0]  tbl_m [256];
  logic [7:0]  exp_q [$];

  bandit_environment #(
    .ACTIONS (256),
    .LATENCY (LAT),
    .SEED    (SEED)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .action_valid (action_valid),
    .action_data  (action_data),
    .action_ready (action_ready),
    .reward_valid (reward_valid),
    .reward_data  (reward_data),
    .reward_ready (reward_ready),
    .cfg_valid    (cfg_valid),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic [15:0] s;
    s = {1'b0, v[15:1]};
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  always @(posedge clock) begin
    if (!reset) lfsr_m <= SEED;
    else        lfsr_m <= ref_step(lfsr_m);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] predict(input logic [7:0] a);
    if (a == 8'd0) return 8'h80;
    if (lfsr_m[7:0] < tbl_m[a]) return 8'h40;
    return 8'hE0;
  endfunction

  task automatic cfg_write(input logic [7:0] a, input logic [7:0] p);
    int n;
    n = 0;
    @(negedge clock);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = p;
    #1;
    while (!cfg_ready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    check_eq("cfg_accept", cfg_ready, 1);
    @(posedge clock);
    tbl_m[a] = p;
    #1 cfg_valid = 1'b0;
  endtask

  // Presents an action until accepted; returns just after the acceptance edge.
  task automatic offer(input logic [7:0] a, output logic [7:0] exp);
    int n;
    n = 0;
    @(negedge clock);
    action_valid = 1'b1; action_data = a;
    #1;
    while (!action_ready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    check_eq("action_accept", action_ready, 1);
    exp = predict(a);
    exp_q.push_back(exp);
    @(posedge clock);
    #1 action_valid = 1'b0;
  endtask

  task automatic collect(input int hold, output logic [7:0] got);
    int edges;
    logic [7:0] exp;
    edges = 0;
    got = 8'd0;
    @(negedge clock); #1;
    while (!reward_valid && edges < 40) begin
      check_eq("busy_action_ready", action_ready, 0);
      check_eq("busy_cfg_ready", cfg_ready, 0);
      @(negedge clock); #1; edges++;
    end
    check_eq("latency", edges, LAT + 1);
    if (!reward_valid) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    repeat (hold) begin
      check_eq("hold_valid", reward_valid, 1);
      check_eq("hold_data", reward_data, exp);
      check_eq("hold_action_ready", action_ready, 0);
      @(negedge clock); #1;
    end
    reward_ready = 1'b1;
    check_eq("reward_data", reward_data, exp);
    got = reward_data;
    @(posedge clock);
    #1 reward_ready = 1'b0;
    @(negedge clock); #1;
    check_eq("valid_drop", reward_valid, 0);
    check_eq("idle_action_ready", action_ready, !cfg_valid);
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] g;
    int wins;

    action_valid = 1'b1; action_data = 8'd7;
    repeat (5) begin
      @(negedge clock); #1;
      check_eq("rst_action_ready", action_ready, 0);
      check_eq("rst_reward_valid", reward_valid, 0);
      check_eq("rst_reward_data", reward_data, 0);
      check_eq("rst_cfg_ready", cfg_ready, 0);
    end
    @(negedge clock);
    reset = 1'b1; action_valid = 1'b0;
    #1;
    check_eq("post_rst_action_ready", action_ready, 1);
    check_eq("post_rst_cfg_ready", cfg_ready, 1);

    cfg_write(8'd7, 8'd0);
    cfg_write(8'd9, 8'd255);
    cfg_write(8'd0, 8'd255);
    cfg_write(8'd42, 8'd128);

    offer(8'd7, e);
    collect(0, g);
    check_eq("loss_p0", g, 8'hE0);

    offer(8'd9, e);
    collect(0, g);
    if (e == 8'h40) check_eq("win_p255", g, 8'h40);

    offer(8'd0, e);
    collect(0, g);
    check_eq("invalid_action0", g, 8'h80);

    offer(8'd42, e);
    collect(20, g);

    // Config and action together: write wins, action follows next cycle.
    @(negedge clock);
    cfg_valid = 1'b1; cfg_addr = 8'd5; cfg_data = 8'd3;
    action_valid = 1'b1; action_data = 8'd7;
    #1;
    check_eq("prio_cfg_ready", cfg_ready, 1);
    check_eq("prio_action_ready", action_ready, 0);
    @(posedge clock);
    tbl_m[5] = 8'd3;
    #1 cfg_valid = 1'b0;
    @(negedge clock); #1;
    check_eq("prio_action_next", action_ready, 1);
    exp_q.push_back(predict(8'd7));
    @(posedge clock);
    #1 action_valid = 1'b0;
    collect(0, g);

    // Config write stalled through DELAY/REWARD, then accepted in IDLE.
    offer(8'd7, e);
    cfg_valid = 1'b1; cfg_addr = 8'd11; cfg_data = 8'd77;
    collect(0, g);
    check_eq("stall_cfg_ready_idle", cfg_ready, 1);
    @(posedge clock);
    tbl_m[11] = 8'd77;
    #1 cfg_valid = 1'b0;
    offer(8'd11, e);
    collect(0, g);

    // Reset during DELAY abandons the reward.
    offer(8'd42, e);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    void'(exp_q.pop_back());
    repeat (10) begin
      @(negedge clock); #1;
      check_eq("abandon_valid", reward_valid, 0);
      check_eq("abandon_idle", action_ready, 1);
    end
    offer(8'd42, e);
    collect(0, g);

    wins = 0;
    for (int i = 0; i < 4000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      offer(8'd42, e);
      collect(0, g);
      if (g == 8'h40) wins++;
    end
    check_eq("win_fraction", (wins >= 1880 && wins <= 2120), 1);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
